ship_placement_ctrl: RTL and testbench
======================================

Name: ship_placement_ctrl

Overview:
Upstream controller for the player's ship-placement phase of the battleship game. It turns the board buttons into a 5x5 cursor position, clears the board, and accepts ship placements. It drives the board-storage block's i_actual, j_actual, colocation_ships_State, decision_State and confirm_colocation_button inputs. It tracks occupied cells and ends the phase once the requested ship count is placed.

Parameters:
GRID_N, 5, board side length; cursor range 0..GRID_N-1
MAX_SHIPS, 5, upper bound on ships per game
REPEAT_CYCLES, 25_000_000, hold time before auto-repeat (used only with the optional feature)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-low
start  in  1  async button level; a rising edge begins or restarts the placement phase
btn_up  in  1  async button level; a rising edge moves the cursor one row up (i-1)
btn_down  in  1  async button level; a rising edge moves the cursor one row down (i+1)
btn_left  in  1  async button level; a rising edge moves the cursor one column left (j-1)
btn_right  in  1  async button level; a rising edge moves the cursor one column right (j+1)
btn_place  in  1  async button level; a rising edge requests a ship at the cursor
num_ships  in  3  requested ship count; sampled on the start edge
i_actual  out  3  cursor row
j_actual  out  3  cursor column
decision_State  out  1  high for exactly one cycle in S_CLEAR; the board clears
colocation_ships_State  out  1  high while in S_PLACE
confirm_colocation_button  out  1  write inhibit, active-high; low for exactly one cycle per accepted placement
ships_placed  out  3  count of accepted ships
placement_done  out  1  high while in S_DONE

Behaviour:
- Reset (rst=0 at posedge clk):
  - state=S_IDLE; i_actual=0; j_actual=0; ships_placed=0.
  - Occupancy mask cleared; latched target=1.
  - decision_State=0, colocation_ships_State=0, placement_done=0, confirm_colocation_button=1.
  - Reset in any state, including mid-placement, aborts the phase without a write pulse.
- Button path: every button goes through a 2-FF synchronizer, then rising-edge detection, giving a 1-cycle pulse 3 cycles after the input edge. Debouncing is external.
- All outputs are registered.
- FSM:
  - S_IDLE: start pulse -> S_CLEAR. Latch target=num_ships, with 0 mapped to 1 and values >MAX_SHIPS clamped to MAX_SHIPS.
  - S_CLEAR: decision_State=1 for one cycle. Clear the occupancy mask, set ships_placed=0 and the cursor to (0,0). Next state is unconditionally S_PLACE.
  - S_PLACE: colocation_ships_State=1. Moves and placements are handled as listed below. A start pulse here -> S_CLEAR (restart), and it takes priority over any place pulse in the same cycle.
  - S_DONE: placement_done=1, cursor frozen. A start pulse -> S_CLEAR with target re-latched.
- Moves in S_PLACE:
  - Cursor moves wrap: 0-1 -> GRID_N-1, and GRID_N-1 +1 -> 0.
  - up and down pulses in the same cycle cancel; left and right pulses in the same cycle cancel.
  - A row move and a column move in the same cycle both apply.
- Placement in S_PLACE:
  - A place pulse is evaluated against the cursor value held before any same-cycle move.
  - If that cell is free: set its occupancy bit, drive confirm_colocation_button=0 for the next cycle only, and increment ships_placed. The write pulse coincides with i_actual/j_actual still equal to the placed cell; any move that cycle is delayed by one cycle.
  - If that cell is occupied: ignore the pulse; no pulse, count unchanged.
  - When ships_placed reaches target: -> S_DONE in the cycle after the write pulse.
- Pulses arriving in S_IDLE, S_CLEAR or S_DONE (other than start) are dropped.

Optional Feature:
AUTO_REPEAT_EN
- Defined: a direction button held synchronized-high for REPEAT_CYCLES generates an extra move pulse, then one more every REPEAT_CYCLES while held. Releasing the button resets its counter. btn_place never repeats.
- Undefined: moves come from edges only; there is no repeat counter logic.

Decomposition:
- Package ship_ctrl_pkg holds:
  - GRID_N default and MAX_SHIPS default;
  - cell codes AGUA=2'b00, BARCO=2'b01, CASILLA_SELECCION=2'b10, CASILLA_CONFIRMADA=2'b11;
  - enum place_state_t {S_IDLE, S_CLEAR, S_PLACE, S_DONE}.
- One sub-module, btn_sync_edge: 2-FF synchronizer plus rising-edge pulse, instantiated 6 times. Under AUTO_REPEAT_EN its repeat counter is also instantiated (4 instances, direction buttons only).

Test Plan:
- Reset then start with num_ships=3 -> decision_State high exactly 1 cycle, then colocation_ships_State=1, cursor (0,0), confirm_colocation_button=1.
- At (0,0): btn_up, then btn_left -> cursor (4,0), then (4,4) (wrap). Three btn_right presses -> (4,2).
- Place at (2,3), then place again at (2,3) -> first press gives one confirm low cycle with i_actual=2, j_actual=3 and ships_placed=1. Second press gives no pulse and count stays 1.
- Place 3 distinct cells with num_ships=3 -> ships_placed=3, placement_done=1, later button presses ignored. start -> decision pulse, count=0.
- btn_place and btn_right in the same synchronized cycle at (1,1) -> write at (1,1), cursor becomes (1,2) one cycle later. btn_up and btn_down together -> cursor unchanged.
- num_ships=0 -> finishes after 1 ship. num_ships=7 -> clamped to 5. rst low mid-S_PLACE -> all outputs at reset values on the next edge.

Source files
------------

// File: rtl/ship_ctrl_pkg.sv
// Shared types and helpers for the ship placement controller.
// Board geometry defaults, cell codes, FSM states and cursor wrap.
package ship_ctrl_pkg;

  localparam int GRID_N_DEF    = 5;
  localparam int MAX_SHIPS_DEF = 5;

  typedef enum logic [1:0] {
    AGUA               = 2'b00,
    BARCO              = 2'b01,
    CASILLA_SELECCION  = 2'b10,
    CASILLA_CONFIRMADA = 2'b11
  } cell_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLEAR,
    S_PLACE,
    S_DONE
  } place_state_t;

  // Cursor step with wrap; delta is -2..+2 (a deferred move plus a new one).
  function automatic logic [2:0] wrap_add(
    input logic        [2:0] pos,
    input logic signed [2:0] d,
    input int                n
  );
    int t;
    t = int'(pos) + int'(d);
    if (t < 0)
      t = t + n;
    else if (t >= n)
      t = t - n;
    return t[2:0];
  endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Button synchronizer and rising-edge pulse generator.
// AUTO_REPEAT_EN adds a hold-to-repeat counter on selected buttons.
module btn_sync_edge
`ifdef AUTO_REPEAT_EN
#(
  parameter bit REPEAT        = 1'b0,
  parameter int REPEAT_CYCLES = 25_000_000
)
`endif
(
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_pulse
);

  logic r_s1;
  logic r_s2;
  logic r_s3;
  logic r_pulse;
  logic w_rep;

`ifdef AUTO_REPEAT_EN
  generate
    if (REPEAT) begin : g_rep
      localparam int CW = $clog2(REPEAT_CYCLES + 1);
      localparam logic [CW-1:0] LAST = CW'(REPEAT_CYCLES - 1);
      logic [CW-1:0] r_cnt;
      // Count cycles held high; wrap and fire each time the hold time elapses.
      always_ff @(posedge clk) begin
        if (!rst || !r_s3)
          r_cnt <= '0;
        else if (r_cnt == LAST)
          r_cnt <= '0;
        else
          r_cnt <= r_cnt + 1'b1;
      end
      assign w_rep = r_s3 && (r_cnt == LAST);
    end else begin : g_norep
      assign w_rep = 1'b0;
    end
  endgenerate
`else
  assign w_rep = 1'b0;
`endif

  // Two-stage synchronizer, edge history and registered pulse.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_s3    <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_s1    <= i_btn;
      r_s2    <= r_s1;
      r_s3    <= r_s2;
      r_pulse <= (r_s2 & ~r_s3) | w_rep;
    end
  end

  assign o_pulse = r_pulse;

endmodule

// File: rtl/ship_placement_ctrl.sv
// Ship placement phase controller: cursor, board clear, placement writes.
// Define AUTO_REPEAT_EN to enable hold-to-repeat on direction buttons.
module ship_placement_ctrl
  import ship_ctrl_pkg::*;
#(
  parameter int GRID_N    = GRID_N_DEF,
  parameter int MAX_SHIPS = MAX_SHIPS_DEF
`ifdef AUTO_REPEAT_EN
  ,
  parameter int REPEAT_CYCLES = 25_000_000
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_place,
  input  logic [2:0] num_ships,
  output logic [2:0] i_actual,
  output logic [2:0] j_actual,
  output logic       decision_State,
  output logic       colocation_ships_State,
  output logic       confirm_colocation_button,
  output logic [2:0] ships_placed,
  output logic       placement_done
);

  localparam int NC = GRID_N * GRID_N;
  localparam int IW = $clog2(NC);

  logic [5:0] w_btn;
  logic [5:0] w_pulse;

  assign w_btn = {btn_place, btn_right, btn_left,
                  btn_down, btn_up, start};

  for (genvar k = 0; k < 6; k++) begin : g_btn
`ifdef AUTO_REPEAT_EN
    btn_sync_edge #(
      .REPEAT        (k >= 1 && k <= 4),
      .REPEAT_CYCLES (REPEAT_CYCLES)
    ) u_btn (
      .clk     (clk),
      .rst     (rst),
      .i_btn   (w_btn[k]),
      .o_pulse (w_pulse[k])
    );
`else
    btn_sync_edge u_btn (
      .clk     (clk),
      .rst     (rst),
      .i_btn   (w_btn[k]),
      .o_pulse (w_pulse[k])
    );
`endif
  end

  logic w_st, w_up, w_dn, w_lf, w_rt, w_pl;
  assign {w_pl, w_rt, w_lf, w_dn, w_up, w_st} = w_pulse;

  place_state_t r_state;
  place_state_t w_next;

  logic [2:0]        r_i;
  logic [2:0]        r_j;
  logic [2:0]        r_count;
  logic [2:0]        r_target;
  logic [NC-1:0]     r_occ;
  logic signed [2:0] r_pdi;
  logic signed [2:0] r_pdj;
  logic              r_dec;
  logic              r_col;
  logic              r_done;
  logic              r_conf;

  logic signed [2:0] w_di;
  logic signed [2:0] w_dj;
  logic [IW-1:0]     w_idx;
  logic [2:0]        w_tgt;
  logic              w_accept;

  assign w_di = (w_dn & ~w_up) ? 3'sd1 :
                (w_up & ~w_dn) ? -3'sd1 : 3'sd0;
  assign w_dj = (w_rt & ~w_lf) ? 3'sd1 :
                (w_lf & ~w_rt) ? -3'sd1 : 3'sd0;

  assign w_idx = IW'(int'(r_i) * GRID_N + int'(r_j));

  assign w_tgt = (num_ships == 3'd0) ? 3'd1 :
                 (num_ships > 3'(MAX_SHIPS)) ? 3'(MAX_SHIPS) :
                 num_ships;

  assign w_accept = (r_state == S_PLACE) && !w_st && w_pl &&
                    !r_occ[w_idx] && (r_count != r_target);

  // Next-state selection; restart wins over everything in S_PLACE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_st) w_next = S_CLEAR;
      S_CLEAR: w_next = S_PLACE;
      S_PLACE: begin
        if (w_st)
          w_next = S_CLEAR;
        else if (r_count == r_target)
          w_next = S_DONE;
      end
      S_DONE:  if (w_st) w_next = S_CLEAR;
      default: w_next = S_IDLE;
    endcase
  end

  // State, board bookkeeping, cursor and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_i      <= '0;
      r_j      <= '0;
      r_count  <= '0;
      r_target <= 3'd1;
      r_occ    <= '0;
      r_pdi    <= '0;
      r_pdj    <= '0;
      r_dec    <= 1'b0;
      r_col    <= 1'b0;
      r_done   <= 1'b0;
      r_conf   <= 1'b1;
    end else begin
      r_state <= w_next;
      r_dec   <= (w_next == S_CLEAR);
      r_col   <= (w_next == S_PLACE);
      r_done  <= (w_next == S_DONE);
      r_conf  <= ~w_accept;
      r_pdi   <= '0;
      r_pdj   <= '0;
      if (w_next == S_CLEAR) begin
        r_occ    <= '0;
        r_count  <= '0;
        r_i      <= '0;
        r_j      <= '0;
        r_target <= w_tgt;
      end else if (r_state == S_PLACE) begin
        if (w_accept) begin
          r_occ[w_idx] <= 1'b1;
          r_count      <= r_count + 3'd1;
          r_pdi        <= w_di;
          r_pdj        <= w_dj;
        end else begin
          r_i <= wrap_add(r_i, w_di + r_pdi, GRID_N);
          r_j <= wrap_add(r_j, w_dj + r_pdj, GRID_N);
        end
      end
    end
  end

  assign i_actual                  = r_i;
  assign j_actual                  = r_j;
  assign ships_placed              = r_count;
  assign decision_State            = r_dec;
  assign colocation_ships_State    = r_col;
  assign placement_done            = r_done;
  assign confirm_colocation_button = r_conf;

endmodule

// File: tb/tb_ship_placement_ctrl.sv
// Scoreboard bench for ship_placement_ctrl.
// Press-level reference model feeds expectation queues.
module tb_ship_placement_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       btn_up = 1'b0;
  logic       btn_down = 1'b0;
  logic       btn_left = 1'b0;
  logic       btn_right = 1'b0;
  logic       btn_place = 1'b0;
  logic [2:0] num_ships = 3'd0;
  logic [2:0] i_actual;
  logic [2:0] j_actual;
  logic       decision_State;
  logic       colocation_ships_State;
  logic       confirm_colocation_button;
  logic [2:0] ships_placed;
  logic       placement_done;

  ship_placement_ctrl dut (
    .clk                       (clk),
    .rst                       (rst),
    .start                     (start),
    .btn_up                    (btn_up),
    .btn_down                  (btn_down),
    .btn_left                  (btn_left),
    .btn_right                 (btn_right),
    .btn_place                 (btn_place),
    .num_ships                 (num_ships),
    .i_actual                  (i_actual),
    .j_actual                  (j_actual),
    .decision_State            (decision_State),
    .colocation_ships_State    (colocation_ships_State),
    .confirm_colocation_button (confirm_colocation_button),
    .ships_placed              (ships_placed),
    .placement_done            (placement_done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input int act,
                     input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  typedef struct {
    int i;
    int j;
    int c;
  } wr_t;

  wr_t q_wr[$];
  int  q_cur[$];
  int  q_cnt[$];
  int  q_clr[$];
  int  q_done[$];

  localparam int P_IDLE  = 0;
  localparam int P_PLACE = 1;
  localparam int P_DONE  = 2;

  int m_i, m_j, m_cnt, m_tgt, m_phase;
  bit m_occ[25];

  bit mon_en = 1'b0;
  int p_cur, p_cnt;
  bit p_done;

  // Monitor: every visible output event must match the next expectation.
  always @(negedge clk) begin
    int cur;
    cur = int'(i_actual) * 8 + int'(j_actual);
    if (mon_en) begin
      if (decision_State) begin
        chk("clr_expected", int'(q_clr.size() > 0), 1);
        if (q_clr.size() > 0) void'(q_clr.pop_front());
        chk("clr_count", int'(ships_placed), 0);
        chk("clr_cursor", cur, 0);
      end
      if (!confirm_colocation_button) begin
        chk("wr_expected", int'(q_wr.size() > 0), 1);
        if (q_wr.size() > 0) begin
          wr_t w;
          w = q_wr.pop_front();
          chk("wr_i", int'(i_actual), w.i);
          chk("wr_j", int'(j_actual), w.j);
          chk("wr_count", int'(ships_placed), w.c);
        end
      end
      if (cur != p_cur) begin
        chk("cur_expected", int'(q_cur.size() > 0), 1);
        if (q_cur.size() > 0)
          chk("cur_value", cur, q_cur.pop_front());
      end
      if (int'(ships_placed) != p_cnt) begin
        chk("cnt_expected", int'(q_cnt.size() > 0), 1);
        if (q_cnt.size() > 0)
          chk("cnt_value", int'(ships_placed),
              q_cnt.pop_front());
      end
      if (placement_done && !p_done) begin
        chk("done_expected", int'(q_done.size() > 0), 1);
        if (q_done.size() > 0)
          chk("done_count", int'(ships_placed),
              q_done.pop_front());
        chk("done_col", int'(colocation_ships_State), 0);
      end
    end
    p_cur  = cur;
    p_cnt  = int'(ships_placed);
    p_done = placement_done;
  end

  task automatic model_reset();
    m_i = 0; m_j = 0; m_cnt = 0; m_tgt = 1;
    m_phase = P_IDLE;
    foreach (m_occ[k]) m_occ[k] = 1'b0;
    q_wr.delete(); q_cur.delete(); q_cnt.delete();
    q_clr.delete(); q_done.delete();
  endtask

  // Press-level model: one button combination, full effect.
  task automatic model_press(input bit st, input bit up,
                             input bit dn, input bit lf,
                             input bit rt, input bit pl,
                             input int ns);
    int di, dj, ni, nj;
    bit placed;
    wr_t w;
    placed = 1'b0;
    if (st) begin
      m_tgt = (ns == 0) ? 1 : (ns > 5) ? 5 : ns;
      if (m_cnt != 0) q_cnt.push_back(0);
      m_cnt = 0;
      foreach (m_occ[k]) m_occ[k] = 1'b0;
      if (m_i != 0 || m_j != 0) q_cur.push_back(0);
      m_i = 0; m_j = 0;
      q_clr.push_back(1);
      m_phase = P_PLACE;
    end else if (m_phase == P_PLACE) begin
      di = int'(dn) - int'(up);
      dj = int'(rt) - int'(lf);
      if (pl && !m_occ[m_i * 5 + m_j]) begin
        m_occ[m_i * 5 + m_j] = 1'b1;
        m_cnt++;
        w.i = m_i; w.j = m_j; w.c = m_cnt;
        q_wr.push_back(w);
        q_cnt.push_back(m_cnt);
        placed = 1'b1;
      end
      ni = (m_i + di + 5) % 5;
      nj = (m_j + dj + 5) % 5;
      if (ni != m_i || nj != m_j) q_cur.push_back(ni * 8 + nj);
      m_i = ni; m_j = nj;
      if (placed && m_cnt == m_tgt) begin
        m_phase = P_DONE;
        q_done.push_back(m_cnt);
      end
    end
  endtask

  task automatic settle_check();
    chk("q_clr_drained", q_clr.size(), 0);
    chk("q_wr_drained", q_wr.size(), 0);
    chk("q_cur_drained", q_cur.size(), 0);
    chk("q_cnt_drained", q_cnt.size(), 0);
    chk("q_done_drained", q_done.size(), 0);
    chk("st_i", int'(i_actual), m_i);
    chk("st_j", int'(j_actual), m_j);
    chk("st_count", int'(ships_placed), m_cnt);
    chk("st_done", int'(placement_done), int'(m_phase == P_DONE));
    chk("st_col", int'(colocation_ships_State),
        int'(m_phase == P_PLACE));
    chk("st_conf", int'(confirm_colocation_button), 1);
  endtask

  task automatic press(input bit st, input bit up, input bit dn,
                       input bit lf, input bit rt, input bit pl,
                       input int ns);
    @(negedge clk);
    num_ships = 3'(ns);
    model_press(st, up, dn, lf, rt, pl, ns);
    start = st; btn_up = up; btn_down = dn;
    btn_left = lf; btn_right = rt; btn_place = pl;
    repeat (2) @(negedge clk);
    start = 0; btn_up = 0; btn_down = 0;
    btn_left = 0; btn_right = 0; btn_place = 0;
    repeat (10) @(negedge clk);
    settle_check();
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_i", int'(i_actual), 0);
    chk("rst_j", int'(j_actual), 0);
    chk("rst_count", int'(ships_placed), 0);
    chk("rst_dec", int'(decision_State), 0);
    chk("rst_col", int'(colocation_ships_State), 0);
    chk("rst_done", int'(placement_done), 0);
    chk("rst_conf", int'(confirm_colocation_button), 1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    mon_en = 1'b1;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    do_reset();
    // Start with three ships, wrap moves.
    press(1, 0, 0, 0, 0, 0, 3);
    press(0, 1, 0, 0, 0, 0, 0);
    press(0, 0, 0, 1, 0, 0, 0);
    repeat (3) press(0, 0, 0, 0, 1, 0, 0);
    // To (2,3), place twice.
    press(0, 1, 0, 0, 0, 0, 0);
    press(0, 1, 0, 0, 0, 0, 0);
    press(0, 0, 0, 0, 1, 0, 0);
    press(0, 0, 0, 0, 0, 1, 0);
    press(0, 0, 0, 0, 0, 1, 0);
    // Up+down cancel, then to (1,1) and place with right.
    press(0, 1, 1, 0, 0, 0, 0);
    press(0, 1, 0, 0, 0, 0, 0);
    press(0, 0, 0, 1, 0, 0, 0);
    press(0, 0, 0, 1, 0, 0, 0);
    press(0, 0, 0, 0, 1, 1, 0);
    press(0, 0, 1, 0, 0, 0, 0);
    press(0, 0, 0, 0, 0, 1, 0);
    // Done: inputs ignored.
    press(0, 1, 0, 0, 0, 0, 0);
    press(0, 0, 0, 0, 1, 1, 0);
    // Zero ships means one.
    press(1, 0, 0, 0, 0, 0, 0);
    press(0, 0, 0, 0, 0, 1, 0);
    // Seven clamps to five.
    press(1, 0, 0, 0, 0, 0, 7);
    repeat (5) press(0, 0, 0, 0, 1, 1, 0);
    // Restart with place in same press, then reset mid-phase.
    press(1, 0, 0, 0, 0, 0, 4);
    press(0, 0, 1, 0, 0, 1, 0);
    press(1, 0, 0, 0, 0, 1, 2);
    press(0, 0, 0, 0, 1, 1, 0);
    do_reset();
    // Randomised presses.
    press(1, 0, 0, 0, 0, 0, 5);
    for (int n = 0; n < 90; n++) begin
      press($urandom_range(0, 11) == 0,
            $urandom_range(0, 3) == 0,
            $urandom_range(0, 3) == 0,
            $urandom_range(0, 3) == 0,
            $urandom_range(0, 3) == 0,
            $urandom_range(0, 1) == 0,
            int'($urandom_range(0, 7)));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
